// File: rtl/hex_display_scanner.sv
// Time-multiplexed N-digit hex 7-segment scanner with shadow register, leading-zero
// suppression, per-digit enable and a one-cycle dead time. Optional blink: HEX_DISPLAY_SCANNER_BLINK_EN.
module hex_display_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic                          lz_blank,
  input  logic [NUM_DIGITS-1:0]         digit_en,
`ifdef HEX_DISPLAY_SCANNER_BLINK_EN
  input  logic [NUM_DIGITS-1:0]         blink_mask,
`endif
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PW    = $clog2(REFRESH_DIV);

  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
    $error("hex_display_scanner: parameter out of range");
  end

  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    tick;
  logic                    blink_hide;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    upper_zero;
  logic [3:0]              nibble;

  function automatic logic [6:0] decode(input logic [3:0] h);
    case (h)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b0011111;
      4'hC:    decode = 7'b1001110;
      4'hD:    decode = 7'b0111101;
      4'hE:    decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign tick   = (presc_q == PW'(REFRESH_DIV - 1));
  assign nibble = shadow_q[4*idx_q +: 4];

  // lz_mask[i] is set when digit i (never digit 0) and everything above it is zero.
  always_comb begin
    upper_zero = 1'b1;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (shadow_q[4*i +: 4] == 4'h0);
      lz_mask[i] = upper_zero & (i > 0);
    end
  end

`ifdef HEX_DISPLAY_SCANNER_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV);
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_hide = phase_q & blink_mask[idx_q];
`else
  assign blink_hide = 1'b0;
`endif

  assign blank = ~digit_en[idx_q] | (lz_blank & lz_mask[idx_q]) | blink_hide;

  // The tick cycle registers an all-off output: this is the anti-ghosting dead time.
  always_comb begin
    shadow_d = load ? value : shadow_q;
    presc_d  = tick ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    sel_d = '0;
    seg_d = '0;
    if (!tick) begin
      sel_d[idx_q] = 1'b1;
      if (!blank) begin
        seg_d = decode(nibble);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      seg_q    <= '0;
      sel_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      sel_q    <= sel_d;
    end
  end

  assign seg_out   = seg_q;
  assign dig_sel   = sel_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner (4 digits, refresh divider 4): vector table, corner
// sequences and random stimulus against a time-indexed reference model.
module tb_hex_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  digit_en = 4'hF;
`ifdef HEX_DISPLAY_SCANNER_BLINK_EN
  logic [3:0]  blink_mask = 4'h0;
`endif
  logic [6:0]  seg_out;
  logic [3:0]  dig_sel;
  logic [1:0]  digit_idx;

  hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLINK_DIV(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .value     (value),
    .load      (load),
    .lz_blank  (lz_blank),
    .digit_en  (digit_en),
`ifdef HEX_DISPLAY_SCANNER_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg_out   (seg_out),
    .dig_sel   (dig_sel),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int          n_pass = 0;
  int          n_total = 0;
  logic [15:0] m_shadow = '0;
  int          m_t = 0;  // clock edges since reset release

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, m_t);
  endtask

  // Output registered at the edge following pre-edge time t.
  function automatic void model_out(input logic [15:0] sh, input int t, input logic lz,
                                    input logic [3:0] en, output logic [6:0] seg,
                                    output logic [3:0] sel);
    int  p;
    int  d;
    logic hide;
    p = t % R;
    d = (t / R) % N;
    seg = '0;
    sel = '0;
    if (p != R - 1) begin
      sel  = 4'(1 << d);
      hide = !en[d];
      if (lz && d > 0 && (sh >> (4 * d)) == 16'h0) hide = 1'b1;
      if (!hide) seg = seg_tab[sh[4*d +: 4]];
    end
  endfunction

  task automatic cycle();
    logic [6:0] es;
    logic [3:0] esel;
    logic [1:0] ei;
    model_out(m_shadow, m_t, lz_blank, digit_en, es, esel);
    @(posedge clk);
    if (load) m_shadow = value;
    m_t++;
    ei = 2'((m_t / R) % N);
    #1;
    check("seg_out", {9'h0, seg_out}, {9'h0, es});
    check("dig_sel", {12'h0, dig_sel}, {12'h0, esel});
    check("digit_idx", {14'h0, digit_idx}, {14'h0, ei});
  endtask

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  en;
    int          digit;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_sel [5];
    logic [6:0] exp_seg [5];
    int         nd;
    bit         hit;

    vecs[0]  = '{16'h1A3F, 1'b0, 4'hF, 0, 7'b1000111};
    vecs[1]  = '{16'h1A3F, 1'b0, 4'hF, 1, 7'b1111001};
    vecs[2]  = '{16'h1A3F, 1'b0, 4'hF, 2, 7'b1110111};
    vecs[3]  = '{16'h1A3F, 1'b0, 4'hF, 3, 7'b0110000};
    vecs[4]  = '{16'h0040, 1'b1, 4'hF, 3, 7'b0000000};
    vecs[5]  = '{16'h0040, 1'b1, 4'hF, 2, 7'b0000000};
    vecs[6]  = '{16'h0040, 1'b1, 4'hF, 1, 7'b0110011};
    vecs[7]  = '{16'h0040, 1'b1, 4'hF, 0, 7'b1111110};
    vecs[8]  = '{16'h0000, 1'b1, 4'hF, 0, 7'b1111110};
    vecs[9]  = '{16'h0000, 1'b1, 4'hF, 1, 7'b0000000};
    vecs[10] = '{16'h0000, 1'b1, 4'hF, 3, 7'b0000000};
    vecs[11] = '{16'hABCD, 1'b0, 4'b1011, 2, 7'b0000000};
    vecs[12] = '{16'hABCD, 1'b0, 4'b1011, 3, 7'b1110111};

    // Reset held from time 0.
    #1;
    check("reset seg_out", {9'h0, seg_out}, 16'h0);
    check("reset dig_sel", {12'h0, dig_sel}, 16'h0);
    check("reset digit_idx", {14'h0, digit_idx}, 16'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    m_t = 0;
    m_shadow = '0;

    // First scan after release.
    exp_sel = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    exp_seg = '{7'b1111110, 7'b1111110, 7'b1111110, 7'b0000000, 7'b1111110};
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("first scan dig_sel", {12'h0, dig_sel}, {12'h0, exp_sel[k]});
      check("first scan seg_out", {9'h0, seg_out}, {9'h0, exp_seg[k]});
    end

    // Vector table: load, then wait for the target digit.
    foreach (vecs[v]) begin
      value = vecs[v].value;
      lz_blank = vecs[v].lz;
      digit_en = vecs[v].en;
      load = 1'b1;
      cycle();
      load = 1'b0;
      hit = 1'b0;
      for (int k = 0; k < 2 * N * R && !hit; k++) begin
        if ((m_t % R) != R - 1 && ((m_t / R) % N) == vecs[v].digit) hit = 1'b1;
        else cycle();
      end
      cycle();
      check("vec seg_out", {9'h0, seg_out}, {9'h0, vecs[v].seg});
      check("vec dig_sel", {12'h0, dig_sel}, 16'(1 << vecs[v].digit));
    end

    // digit_idx wraps 3 -> 0 at the end of the frame.
    lz_blank = 1'b0;
    digit_en = 4'hF;
    for (int k = 0; k < N * R && !((m_t % R) == R - 1 && ((m_t / R) % N) == N - 1); k++) cycle();
    cycle();
    check("idx wrap", {14'h0, digit_idx}, 16'h0);

    // Load coinciding with tick: the next digit shows the new value.
    for (int k = 0; k < R && (m_t % R) != R - 1; k++) cycle();
    value = 16'hFFFF;
    load = 1'b1;
    cycle();
    load = 1'b0;
    nd = (m_t / R) % N;
    cycle();
    check("load@tick seg_out", {9'h0, seg_out}, 16'h0047);
    check("load@tick dig_sel", {12'h0, dig_sel}, 16'(1 << nd));

    // Randomized stimulus against the model.
    for (int k = 0; k < 300; k++) begin
      value = 16'($urandom);
      load = ($urandom_range(0, 3) == 0);
      lz_blank = 1'($urandom_range(0, 1));
      digit_en = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      cycle();
    end
    load = 1'b0;

    // Asynchronous reset mid-scan, then restart at digit 0 with cleared shadow.
    for (int k = 0; k < R && ((m_t / R) % N) == 0; k++) cycle();
    #3 rst_n = 1'b0;
    #1;
    check("async rst seg_out", {9'h0, seg_out}, 16'h0);
    check("async rst dig_sel", {12'h0, dig_sel}, 16'h0);
    check("async rst digit_idx", {14'h0, digit_idx}, 16'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_t = 0;
    m_shadow = '0;
    lz_blank = 1'b0;
    digit_en = 4'hF;
    for (int k = 0; k < 2 * N * R; k++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Time-multiplexed driver for an N-digit common-select 7-segment display.
- Latches a hex value of 4*NUM_DIGITS bits and scans one digit at a time at a programmable refresh rate.
- Per digit: hex-to-segment decode, one-hot digit select, leading-zero suppression and a one-cycle anti-ghosting dead time between digits.
- Sits between the datapath value registers and the board display pins. Supersedes the two-digit combinational decoder.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles each digit is held (>=2).
- BLINK_DIV, 25000000, cycles per blink half-period (used only with BLINK_EN).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value  input  4*NUM_DIGITS  hex value; nibble [3:0] is digit 0, the least significant.
- load  input  1  capture value into the shadow register.
- lz_blank  input  1  enables leading-zero suppression.
- digit_en  input  NUM_DIGITS  per-digit enable mask; 0 blanks that digit.
- seg_out  output  7  segments {a,b,c,d,e,f,g}, active high, registered.
- dig_sel  output  NUM_DIGITS  one-hot digit select, active high, registered.
- digit_idx  output  clog2(NUM_DIGITS)  index of the digit currently being scanned.

Behaviour:
- Reset is asynchronous: rst_n=0 immediately forces the following, regardless of clk:
  - shadow=0, prescaler=0, digit_idx=0;
  - seg_out=7'b0000000, dig_sel=0;
  - blink phase=0, when BLINK_EN is defined.
- Reset asserted mid-scan aborts the scan; after release, scanning restarts at digit 0.
- Shadow register: load=1 at a clk edge captures value. The new value appears on seg_out at the next output update, i.e. 1 cycle after capture.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = (prescaler==REFRESH_DIV-1).
  - On tick, digit_idx increments modulo NUM_DIGITS, so NUM_DIGITS-1 wraps to 0.
- Outputs are registered and updated every cycle from the current digit_idx and shadow.
  - In the cycle where tick=1, the next-state outputs are dig_sel=0 and seg_out=0. This is a one-cycle dead time.
  - In all other cycles, dig_sel = one-hot(digit_idx) and seg_out = decode(shadow nibble[digit_idx]).
- Each digit is visibly driven for REFRESH_DIV-1 cycles per scan. The full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Decode table (hex -> abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111
- Blanking: a blanked digit keeps dig_sel asserted but drives seg_out=0. Blanking conditions:
  - digit_en[i]=0; or
  - lz_blank=1, i>0, and nibbles i..NUM_DIGITS-1 are all zero.
- Digit 0 is never suppressed by lz_blank, so value 0 displays "0".
- lz_blank and digit_en are sampled live each cycle and are not shadowed.
- Simultaneous load and tick: both take effect at the same edge. The next digit shows the new value.
- load held high: the shadow tracks value every cycle.

Optional Feature:
- Macro: HEX_DISPLAY_SCANNER_BLINK_EN.
- When defined:
  - Adds input blink_mask [NUM_DIGITS-1:0].
  - A blink counter of BLINK_DIV cycles toggles the blink phase.
  - While phase=1, digits with blink_mask[i]=1 are blanked (seg_out=0, dig_sel still asserted).
  - Phase resets to 0, so digits are visible first.
- When undefined: no blink_mask port, no blink counter; behaviour is exactly as above.

Test Plan:
- Reset and first scan (NUM_DIGITS=4, REFRESH_DIV=4):
  - Assert rst_n=0 asynchronously mid-cycle -> seg_out=0 and dig_sel=0 immediately.
  - Release, no load -> dig_sel=0001, seg_out=1111110 for 3 cycles, then one dead cycle with dig_sel=0000, then dig_sel=0010.
- Load and full frame:
  - load value=16'h1A3F -> per-digit seg_out is 1000111 (digit 0), 1111001 (digit 1), 1110111 (digit 2), 0110000 (digit 3).
  - digit_idx wraps 3->0 after 16 cycles.
- Leading-zero suppression: value=16'h0040, lz_blank=1 -> digits 3 and 2 give seg_out=0; digit 1 gives 0110011; digit 0 gives 1111110.
  - value=0, lz_blank=1 -> only digit 0 shows 1111110.
- Enable mask and simultaneous events:
  - digit_en=4'b1011 -> digit 2 gives seg_out=0 while dig_sel=0100.
  - Pulse load with value=16'hFFFF on a tick cycle -> the next digit shows 1000111.
- Blink, built with HEX_DISPLAY_SCANNER_BLINK_EN and BLINK_DIV=32: blink_mask=4'b0001 -> digit 0 alternates between its decoded segments and 0000000 every 32 cycles; other digits are unaffected.
